id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: N, 32, datapath width of PC, operand and immediate fields.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: stall  input  1  hold all registered outputs unchanged.
REQ-005 Port: flush  input  1  replace captured instruction with a bubble.
REQ-006 Port: id_valid  input  1  ID stage presents a real instruction.
REQ-007 Port: id_pc, id_rs_data, id_rt_data, id_imm  input  N each  decode-stage PC, operands, sign-extended immediate.
REQ-008 Port: id_rs_addr, id_rt_addr, id_rd_addr  input  5 each  register indices.
REQ-009 Port: id_alu_src  input  1  0 selects rt operand, 1 selects immediate, for the ALU-B select downstream.
REQ-010 Port: id_alu_op  input  4  ALU operation code.
REQ-011 Port: id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  control bits.
REQ-012 Port: wb_reg_write  input  1, wb_addr  input  5, wb_data  input  N  write-back bus for same-cycle bypass.
REQ-013 Port: ex_* outputs mirroring REQ-007..REQ-011 with identical widths, plus ex_valid  output  1.
REQ-014 Port: bubble_cnt  output  16  saturating count of bubbles inserted.

Function
REQ-015 Capture: on rising edge with rst_n=1, stall=0, flush=0, all ex_* outputs SHALL load their id_* counterparts; latency exactly 1 cycle.
REQ-016 Bypass: when wb_reg_write=1, wb_addr!=0 and wb_addr==id_rs_addr, ex_rs_data SHALL load wb_data instead of id_rs_data; same rule independently for rt.
REQ-017 Bypass on register 0 SHALL never occur; wb_addr=0 always passes id data.
REQ-018 Stall: stall=1 and flush=0 SHALL hold every output, including ex_valid, and disable bypass capture.
REQ-019 Flush: flush=1 SHALL clear ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg to 0 and SHALL leave data/address fields don't-care; flush SHALL take priority over stall.
REQ-020 Bubble: id_valid=0 on a capture edge SHALL be treated as flush (control bits cleared, ex_valid=0).
REQ-021 Counter: bubble_cnt SHALL increment by 1 on each edge where flush=1, or where stall=1 (EX receives no new instruction); SHALL saturate at 16'hFFFF, never wrap.
REQ-022 State: two-state FSM, RUN and HOLD; RUN->HOLD when stall=1 and flush=0; HOLD->RUN when stall=0 or flush=1; HOLD re-asserts held outputs unchanged.
REQ-023 Outputs SHALL be purely registered; no combinational path from any input to any output.

Reset
REQ-024 rst_n=0 at a rising edge SHALL clear all ex_* outputs, ex_valid and bubble_cnt to 0 and force state RUN, overriding stall and flush.
REQ-025 Reset asserted mid-stall SHALL discard the held instruction; first edge after release behaves per REQ-015.

Structure
REQ-026 Shared package SHALL hold: register-index width 5, ALU-op width 4, ALU-op code constants, bubble counter width 16, FSM state encodings.
REQ-027 One sub-module wb_bypass (operand + write-back address compare -> selected N-bit operand) SHALL be instantiated twice, for rs and rt.

Verification
REQ-028 Capture: id_rs_data=32'h0000_1234, id_alu_src=1, id_valid=1 -> next cycle ex_rs_data=32'h0000_1234, ex_alu_src=1, ex_valid=1.
REQ-029 Bypass: id_rs_addr=5, wb_reg_write=1, wb_addr=5, wb_data=32'hDEAD_BEEF -> ex_rs_data=32'hDEAD_BEEF; repeat with wb_addr=0 -> ex_rs_data=id_rs_data.
REQ-030 Stall: capture instr A, then stall=1 for 3 cycles with new id data -> outputs stay A for 3 cycles, bubble_cnt=3.
REQ-031 Flush+stall same cycle with id_reg_write=1 -> ex_valid=0, ex_reg_write=0, bubble_cnt incremented by 1.
REQ-032 Saturation: preload 65534 bubbles, apply 3 flushes -> bubble_cnt=16'hFFFF.
REQ-033 Reset during stall: rst_n=0 one edge -> all outputs 0, next normal capture loads id values.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared widths, ALU op codes and FSM states for the ID/EX register
// Purpose: common constants for id_ex_reg and wb_bypass.
// Ports: none (package).
package id_ex_reg_pkg;

  localparam int REG_AW       = 5;
  localparam int ALU_OP_W     = 4;
  localparam int BUBBLE_CNT_W = 16;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'hA;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Saturating increment for the bubble counter.
  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (v == {BUBBLE_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_bypass.sv
// rtl/wb_bypass.sv - selects write-back data over a decode operand on a register-index match
// Purpose: same-cycle write-back forwarding for one source operand.
// Ports:
//   id_data      decode-stage operand value
//   id_addr      decode-stage register index of that operand
//   wb_reg_write write-back stage is writing the register file
//   wb_addr      write-back destination index
//   wb_data      write-back value
//   sel_data     operand to capture into EX
module wb_bypass
  import id_ex_reg_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]      id_data,
  input  logic [REG_AW-1:0] id_addr,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [N-1:0]      wb_data,
  output logic [N-1:0]      sel_data
);

  logic hit;

  // Register 0 is hardwired zero, so a write to it must never be forwarded.
  assign hit      = wb_reg_write && (wb_addr != '0) && (wb_addr == id_addr);
  assign sel_data = hit ? wb_data : id_data;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush, WB bypass and bubble counter
// Purpose: registers decode-stage fields into EX; stall holds, flush or an invalid
//          instruction inserts a bubble; counts inserted bubbles (saturating).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   stall, flush         hold request, bubble request (flush wins)
//   id_*                 decode-stage instruction fields and control bits
//   wb_reg_write/addr/data write-back bus forwarded into rs/rt capture
//   ex_*                 registered copies of the id_* fields, plus ex_valid
//   bubble_cnt           saturating count of flush/stall edges
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [N-1:0]            id_pc,
  input  logic [N-1:0]            id_rs_data,
  input  logic [N-1:0]            id_rt_data,
  input  logic [N-1:0]            id_imm,
  input  logic [REG_AW-1:0]       id_rs_addr,
  input  logic [REG_AW-1:0]       id_rt_addr,
  input  logic [REG_AW-1:0]       id_rd_addr,
  input  logic                    id_alu_src,
  input  logic [ALU_OP_W-1:0]     id_alu_op,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    id_mem_to_reg,
  input  logic                    wb_reg_write,
  input  logic [REG_AW-1:0]       wb_addr,
  input  logic [N-1:0]            wb_data,
  output logic                    ex_valid,
  output logic [N-1:0]            ex_pc,
  output logic [N-1:0]            ex_rs_data,
  output logic [N-1:0]            ex_rt_data,
  output logic [N-1:0]            ex_imm,
  output logic [REG_AW-1:0]       ex_rs_addr,
  output logic [REG_AW-1:0]       ex_rt_addr,
  output logic [REG_AW-1:0]       ex_rd_addr,
  output logic                    ex_alu_src,
  output logic [ALU_OP_W-1:0]     ex_alu_op,
  output logic                    ex_reg_write,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic                    ex_mem_to_reg,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  state_e      state, next_state;
  logic        load_en;
  logic        bubble_inc;
  logic        keep_ctrl;
  logic [N-1:0] rs_sel, rt_sel;

  wb_bypass #(.N(N)) u_rs_bypass (
    .id_data      (id_rs_data),
    .id_addr      (id_rs_addr),
    .wb_reg_write (wb_reg_write),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .sel_data     (rs_sel)
  );

  wb_bypass #(.N(N)) u_rt_bypass (
    .id_data      (id_rt_data),
    .id_addr      (id_rt_addr),
    .wb_reg_write (wb_reg_write),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .sel_data     (rt_sel)
  );

  // Load whenever not purely stalled; flush overrides stall so the bubble
  // is always written even while the front end is holding.
  always_comb begin
    next_state = state;
    load_en    = 1'b1;
    bubble_inc = flush || stall;
    case (state)
      ST_RUN: begin
        if (stall && !flush) begin
          next_state = ST_HOLD;
          load_en    = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!stall || flush) begin
          next_state = ST_RUN;
        end else begin
          load_en = 1'b0;
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  // An invalid decode slot is captured exactly like a flush.
  assign keep_ctrl = id_valid && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs_addr    <= '0;
      ex_rt_addr    <= '0;
      ex_rd_addr    <= '0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      bubble_cnt    <= '0;
    end else begin
      state <= next_state;
      if (bubble_inc) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
      if (load_en) begin
        ex_valid      <= keep_ctrl;
        ex_pc         <= id_pc;
        ex_rs_data    <= rs_sel;
        ex_rt_data    <= rt_sel;
        ex_imm        <= id_imm;
        ex_rs_addr    <= id_rs_addr;
        ex_rt_addr    <= id_rt_addr;
        ex_rd_addr    <= id_rd_addr;
        ex_alu_src    <= id_alu_src;
        ex_alu_op     <= id_alu_op;
        ex_reg_write  <= id_reg_write  && keep_ctrl;
        ex_mem_read   <= id_mem_read   && keep_ctrl;
        ex_mem_write  <= id_mem_write  && keep_ctrl;
        ex_mem_to_reg <= id_mem_to_reg && keep_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - self-checking bench for id_ex_reg against a behavioural model
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic        ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [15:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  rsa, rta, rda;
    logic        src;
    logic [3:0]  op;
    logic        rw, mr, mw, m2r;
  } exp_t;

  exp_t m;
  int   m_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_rd_addr(ex_rd_addr), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (wb_reg_write && wb_addr != 5'd0 && wb_addr == a) return wb_data;
    return d;
  endfunction

  // Reference behaviour: reset clears, a plain stall holds, otherwise the slot
  // is loaded and only survives as a real instruction if valid and not flushed.
  task automatic model_edge();
    logic live;
    if (!rst_n) begin
      m     = '0;
      m_cnt = 0;
    end else begin
      if (flush || stall) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (flush || !stall) begin
        live  = id_valid && !flush;
        m.v   = live;
        m.pc  = id_pc;
        m.rs  = fwd(id_rs_addr, id_rs_data);
        m.rt  = fwd(id_rt_addr, id_rt_data);
        m.imm = id_imm;
        m.rsa = id_rs_addr;
        m.rta = id_rt_addr;
        m.rda = id_rd_addr;
        m.src = id_alu_src;
        m.op  = id_alu_op;
        m.rw  = live && id_reg_write;
        m.mr  = live && id_mem_read;
        m.mw  = live && id_mem_write;
        m.m2r = live && id_mem_to_reg;
      end
    end
  endtask

  task automatic check_model(input bit full);
    check("valid", {31'd0, ex_valid}, {31'd0, m.v});
    check("ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
          {28'd0, m.rw, m.mr, m.mw, m.m2r});
    check("bubble_cnt", {16'd0, bubble_cnt}, m_cnt[31:0]);
    // Data fields are don't-care in a bubble; after reset they must be zero.
    if (full || m.v) begin
      check("pc", ex_pc, m.pc);
      check("rs_data", ex_rs_data, m.rs);
      check("rt_data", ex_rt_data, m.rt);
      check("imm", ex_imm, m.imm);
      check("addrs", {17'd0, ex_rs_addr, ex_rt_addr, ex_rd_addr}, {17'd0, m.rsa, m.rta, m.rda});
      check("alu", {27'd0, ex_alu_src, ex_alu_op}, {27'd0, m.src, m.op});
    end
  endtask

  task automatic tick(input bit do_check = 1'b1);
    bit was_rst;
    was_rst = !rst_n;
    @(posedge clk);
    model_edge();
    #1;
    if (do_check) check_model(was_rst);
  endtask

  task automatic rand_id();
    id_valid      = ($urandom_range(0, 7) != 0);
    id_pc         = $urandom;
    id_rs_data    = $urandom;
    id_rt_data    = $urandom;
    id_imm        = $urandom;
    id_rs_addr    = 5'($urandom_range(0, 7));
    id_rt_addr    = 5'($urandom_range(0, 7));
    id_rd_addr    = 5'($urandom);
    id_alu_src    = 1'($urandom);
    id_alu_op     = 4'($urandom);
    id_reg_write  = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
    wb_reg_write  = 1'($urandom);
    wb_addr       = 5'($urandom_range(0, 7));
    wb_data       = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a_pc, a_rs;
    int          c0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    rand_id();
    stall = 1'b1; flush = 1'b1;
    tick();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    stall = 1'b0; flush = 1'b0; rst_n = 1'b1;

    // Basic capture
    rand_id();
    id_valid = 1'b1; id_rs_data = 32'h0000_1234; id_alu_src = 1'b1; wb_reg_write = 1'b0;
    tick();
    check("cap_rs", ex_rs_data, 32'h0000_1234);
    check("cap_src", {31'd0, ex_alu_src}, 32'd1);
    check("cap_valid", {31'd0, ex_valid}, 32'd1);

    // Bypass hit, then register 0 never forwards
    rand_id();
    id_valid = 1'b1; id_rs_addr = 5'd5; wb_reg_write = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    check("byp_hit", ex_rs_data, 32'hDEAD_BEEF);
    id_rs_addr = 5'd0; wb_addr = 5'd0; a_rs = id_rs_data;
    tick();
    check("byp_r0", ex_rs_data, a_rs);

    // Stall for 3 cycles holds instruction A
    do_reset();
    rand_id();
    id_valid = 1'b1; a_pc = id_pc;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      check("stall_hold_pc", ex_pc, a_pc);
    end
    check("stall_cnt", {16'd0, bubble_cnt}, 32'd3);

    // Flush and stall together
    stall = 1'b1; flush = 1'b1; rand_id(); id_valid = 1'b1; id_reg_write = 1'b1;
    c0 = m_cnt;
    tick();
    check("fs_valid", {31'd0, ex_valid}, 32'd0);
    check("fs_rw", {31'd0, ex_reg_write}, 32'd0);
    check("fs_cnt", {16'd0, bubble_cnt}, 32'(c0 + 1));

    // Reset during a stall, then a normal capture
    flush = 1'b0; stall = 1'b1; rand_id(); id_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("rs_stall_valid", {31'd0, ex_valid}, 32'd0);
    check("rs_stall_cnt", {16'd0, bubble_cnt}, 32'd0);
    rst_n = 1'b1; stall = 1'b0; rand_id(); id_valid = 1'b1; a_pc = id_pc;
    tick();
    check("rs_cap_pc", ex_pc, a_pc);
    check("rs_cap_valid", {31'd0, ex_valid}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 39) != 0);
      tick();
    end

    // Counter saturation
    stall = 1'b0; flush = 1'b0;
    do_reset();
    flush = 1'b1;
    for (int i = 0; i < 65534; i++) tick(1'b0);
    #1;
    check("sat_pre", {16'd0, bubble_cnt}, 32'd65534);
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
    end
    check("sat_ffff", {16'd0, bubble_cnt}, 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
